// File: rtl/iir2_inverse_mac_if.sv
// Sample stream bundle for the inverse IIR block: filtered samples in, recovered samples out.
// The master side offers yn and accepts xn; the slave side is the block itself.
interface iir2_inverse_mac_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] yn;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] xn;

  modport master (
    output in_valid, yn, out_ready,
    input  in_ready, out_valid, xn
  );

  modport slave (
    input  in_valid, yn, out_ready,
    output in_ready, out_valid, xn
  );
endinterface

// File: rtl/iir2_inverse_mac.sv
// Inverse 2nd-order IIR: recovers x[n] = y[n] - b1*x1 - b2*x2 - a1*y1 - a2*y2 (mod 2^W)
// using one shared multiplier sequenced over four MAC steps per sample.
module iir2_inverse_mac #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [W-1:0]          a1,
  input  logic [W-1:0]          a2,
  input  logic [W-1:0]          b1,
  input  logic [W-1:0]          b2,
  iir2_inverse_mac_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   k;
  logic [W-1:0] acc;
  logic [W-1:0] ylat;
  logic [W-1:0] ca1, ca2, cb1, cb2;
  logic [W-1:0] x1, x2, y1, y2;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [W-1:0] xn_q;

  logic [W-1:0] mul_c;
  logic [W-1:0] mul_h;
  logic [W-1:0] prod;
  logic [W-1:0] acc_next;

  // Step k picks which latched coefficient meets which history tap.
  always_comb begin
    // NOTE: defaults first so every path assigns both operands and no latch is inferred.
    mul_c = '0;
    mul_h = '0;
    unique case (k)
      2'd0: begin mul_c = cb1; mul_h = x1; end
      2'd1: begin mul_c = cb2; mul_h = x2; end
      2'd2: begin mul_c = ca1; mul_h = y1; end
      2'd3: begin mul_c = ca2; mul_h = y2; end
      default: ;
    endcase
  end

  // Product is truncated to W bits in the assignment context, giving the mod-2^W result.
  assign prod     = mul_c * mul_h;
  assign acc_next = acc - prod;

  // NOTE: every register here is a flop, so all updates use non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= 2'd0;
      acc         <= '0;
      ylat        <= '0;
      ca1         <= '0;
      ca2         <= '0;
      cb1         <= '0;
      cb2         <= '0;
      x1          <= '0;
      x2          <= '0;
      y1          <= '0;
      y2          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      xn_q        <= '0;
    end else if (clr) begin
      // Flush wins over any handshake in the same cycle, including a pending input.
      state       <= IDLE;
      k           <= 2'd0;
      acc         <= '0;
      x1          <= '0;
      x2          <= '0;
      y1          <= '0;
      y2          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      xn_q        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            acc        <= bus.yn;
            ylat       <= bus.yn;
            ca1        <= a1;
            ca2        <= a2;
            cb1        <= b1;
            cb2        <= b2;
            k          <= 2'd0;
            in_ready_q <= 1'b0;
            state      <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == 2'd3) begin
            xn_q        <= acc_next;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            k <= k + 2'd1;
          end
        end
        DONE: begin
          // History only moves once the sample has actually left the block.
          if (out_valid_q && bus.out_ready) begin
            x2          <= x1;
            x1          <= acc;
            y2          <= y1;
            y1          <= ylat;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.xn        = xn_q;

endmodule

// File: tb/tb_iir2_inverse_mac.sv
// Directed bench for iir2_inverse_mac: hand-computed vectors, backpressure, flush/reset
// recovery, and a forward-filter round trip with a small reference model.
module tb_iir2_inverse_mac;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] a1, a2, b1, b2;
  int         n_cmp;
  int         n_bad;

  iir2_inverse_mac_if #(.W(8)) bus ();

  iir2_inverse_mac #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .a1    (a1),
    .a2    (a2),
    .b1    (b1),
    .b2    (b2),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic set_coefs(input logic [7:0] na1, input logic [7:0] na2,
                           input logic [7:0] nb1, input logic [7:0] nb2);
    a1 = na1; a2 = na2; b1 = nb1; b2 = nb2;
  endtask

  // Offer one sample, verify latency and result, optionally stall the output for
  // `stall` cycles, optionally scramble coefficient inputs while the sample is in flight.
  task automatic send(input logic [7:0] yv, input logic [7:0] exp, input string tag,
                      input int stall, input bit scramble);
    int         n;
    logic [7:0] hist_x1, hist_y1;
    logic [7:0] sa1, sa2, sb1, sb2;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (!bus.in_ready) check({tag, "_rdy_timeout"}, 32'd0, 32'd1);
    hist_x1       = dut.x1;
    hist_y1       = dut.y1;
    bus.yn        = yv;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    step();
    bus.in_valid = 1'b0;
    sa1 = a1; sa2 = a2; sb1 = b1; sb2 = b2;
    if (scramble) set_coefs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 32'd4);
    check({tag, "_xn"}, bus.xn, exp);
    for (int i = 0; i < stall; i++) begin
      check({tag, "_bp_xn"}, bus.xn, exp);
      check({tag, "_bp_vld"}, bus.out_valid, 32'd1);
      check({tag, "_bp_rdy"}, bus.in_ready, 32'd0);
      check({tag, "_bp_x1"}, dut.x1, hist_x1);
      check({tag, "_bp_y1"}, dut.y1, hist_y1);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    if (scramble) set_coefs(sa1, sa2, sb1, sb2);
    if (stall > 0) begin
      check({tag, "_hs_vld"}, bus.out_valid, 32'd0);
      check({tag, "_hs_rdy"}, bus.in_ready, 32'd1);
      check({tag, "_hs_x1"}, dut.x1, exp);
      check({tag, "_hs_y1"}, dut.y1, yv);
    end
  endtask

  initial begin
    logic [7:0] fx1, fx2, fy1, fy2, x, y;
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.yn        = '0;
    bus.out_ready = 1'b1;
    set_coefs(8'h00, 8'h00, 8'h00, 8'h00);
    #12;
    check("rst_in_ready", bus.in_ready, 32'd1);
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_xn", bus.xn, 32'd0);
    rst_n = 1'b1;
    step();

    // Pass-through with zero coefficients.
    send(8'h12, 8'h12, "zero_a", 0, 1'b0);
    send(8'h34, 8'h34, "zero_b", 0, 1'b0);
    send(8'hFF, 8'hFF, "zero_c", 0, 1'b0);

    // b1=1: x = 5, 7-5=2, 2-2=0.
    do_clr();
    set_coefs(8'h00, 8'h00, 8'h01, 8'h00);
    send(8'd5, 8'd5, "b1_a", 0, 1'b0);
    send(8'd7, 8'd2, "b1_b", 0, 1'b0);
    send(8'd2, 8'd0, "b1_c", 0, 1'b0);

    // a1=1 wrap: 3, then 1-3=0xFE; then a1=0x10 with y1=1: 0x20-0x10=0x10.
    do_clr();
    set_coefs(8'h01, 8'h00, 8'h00, 8'h00);
    send(8'h03, 8'h03, "wrap_a", 0, 1'b0);
    send(8'h01, 8'hFE, "wrap_b", 0, 1'b0);
    set_coefs(8'h10, 8'h00, 8'h00, 8'h00);
    send(8'h20, 8'h10, "wrap_c", 0, 1'b0);

    // Backpressure: 10 stalled cycles, then the next sample shows history advanced once.
    do_clr();
    set_coefs(8'h00, 8'h00, 8'h01, 8'h00);
    send(8'h40, 8'h40, "bp", 10, 1'b0);
    send(8'h45, 8'h05, "bp_next", 0, 1'b0);

    // Round trip through a forward-filter model, coefficients scrambled mid-flight.
    do_clr();
    set_coefs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    fx1 = '0; fx2 = '0; fy1 = '0; fy2 = '0;
    for (int i = 0; i < 64; i++) begin
      x = 8'($urandom);
      y = x + b1 * fx1 + b2 * fx2 + a1 * fy1 + a2 * fy2;
      send(y, x, $sformatf("rt%0d", i), (i % 16 == 5) ? 2 : 0, i[0]);
      fx2 = fx1; fx1 = x;
      fy2 = fy1; fy1 = y;
    end

    // Reset pulse during MAC step k=2 drops the sample and clears history.
    set_coefs(8'h00, 8'h00, 8'h00, 8'h00);
    send(8'h21, 8'h21, "pre_rst", 0, 1'b0);
    bus.yn       = 8'h33;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check("mac_k2", dut.k, 32'd2);
    rst_n = 1'b0;
    #2;
    check("midrst_out_valid", bus.out_valid, 32'd0);
    check("midrst_in_ready", bus.in_ready, 32'd1);
    check("midrst_xn", bus.xn, 32'd0);
    check("midrst_x1", dut.x1, 32'd0);
    check("midrst_y1", dut.y1, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    send(8'h09, 8'h09, "after_rst", 0, 1'b0);

    // clr while DONE with in_valid high: flush wins, the new sample is not taken.
    bus.yn        = 8'h50;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    check("pre_clr_valid", bus.out_valid, 32'd1);
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.yn       = 8'h77;
    step();
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("clr_out_valid", bus.out_valid, 32'd0);
    check("clr_in_ready", bus.in_ready, 32'd1);
    check("clr_xn", bus.xn, 32'd0);
    check("clr_x1", dut.x1, 32'd0);
    check("clr_y1", dut.y1, 32'd0);
    step();
    check("clr_not_accepted", bus.in_ready, 32'd1);
    send(8'h09, 8'h09, "after_clr", 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
